// File: rtl/ahb_sub_pkg.sv
// Shared AHB-Lite encodings and the SRAM subordinate's FSM state type.
package ahb_sub_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_ERR1 = 2'b10,
    ST_ERR2 = 2'b11
  } ahbsub_state_t;

  localparam logic [2:0] HSIZE_B = 3'd0;
  localparam logic [2:0] HSIZE_H = 3'd1;
  localparam logic [2:0] HSIZE_W = 3'd2;
  localparam logic [2:0] HSIZE_D = 3'd3;

  // Low-address bits that must be zero for a transfer of the given size.
  function automatic logic [6:0] size_mask(input logic [2:0] hsize);
    return (7'd1 << hsize) - 7'd1;
  endfunction

endpackage

// File: rtl/ahb_sub_bytemem.sv
// DEPTH x W word array: combinational read, per-byte strobed write on the clock edge when en is high.
module ahb_sub_bytemem #(
  parameter int W     = 64,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            en,
  input  logic [AW-1:0]   addr,
  input  logic [W-1:0]    wdata,
  input  logic [W/8-1:0]  strb,
  output logic [W-1:0]    rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < W/8; b++) begin
        if (strb[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite SRAM window: zero or WAIT_STATES wait cycles per transfer, write committed on the completing edge.
// AHB_SRAM_ERR_RESP_EN enables two-cycle ERROR responses for out-of-window, misaligned or oversized accesses.
module ahb_sram_subordinate
  import ahb_sub_pkg::*;
#(
  parameter int                  AHBW        = 64,
  parameter int                  PA_BITS     = 34,
  parameter logic [PA_BITS-1:0]  BASE        = 'h8000_0000,
  parameter int                  DEPTH       = 1024,
  parameter int                  WAIT_STATES = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 HSEL,
  input  logic [PA_BITS-1:0]   HADDR,
  input  logic [1:0]           HTRANS,
  input  logic                 HWRITE,
  input  logic [2:0]           HSIZE,
  input  logic [2:0]           HBURST,
  input  logic [3:0]           HPROT,
  input  logic                 HMASTLOCK,
  input  logic [AHBW-1:0]      HWDATA,
  input  logic [AHBW/8-1:0]    HWSTRB,
  input  logic                 HREADY,
  output logic [AHBW-1:0]      HRDATA,
  output logic                 HREADYOUT,
  output logic                 HRESP
);

  localparam int OFFB = $clog2(AHBW/8);
  localparam int IDXB = $clog2(DEPTH);

  ahbsub_state_t        state;
  logic [3:0]           cnt;
  logic [PA_BITS-1:0]   addr_q;
  logic                 write_q;
  logic [2:0]           size_q;
  logic                 accept;
  logic                 err;
  logic                 commit;
  logic [AHBW-1:0]      mem_rdata;

  assign accept = HSEL & HREADY & HTRANS[1];

`ifdef AHB_SRAM_ERR_RESP_EN
  localparam logic [PA_BITS:0] LIMIT = {1'b0, BASE} + (PA_BITS+1)'(DEPTH * (AHBW/8));

  assign err = ({1'b0, HADDR} < {1'b0, BASE}) |
               ({1'b0, HADDR} >= LIMIT) |
               ((HADDR[6:0] & size_mask(HSIZE)) != 7'd0) |
               (HSIZE > 3'(OFFB));
  assign HRESP = (state == ST_ERR1) | (state == ST_ERR2);
`else
  assign err   = 1'b0;
  assign HRESP = 1'b0;
`endif

  always_comb begin
    HREADYOUT = 1'b1;
    case (state)
      ST_DATA: HREADYOUT = (cnt == 4'd0);
      ST_ERR1: HREADYOUT = 1'b0;
      default: HREADYOUT = 1'b1;
    endcase
  end

  // A new address phase is only taken when the current data phase (if any) completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else if (HREADYOUT) begin
      if (accept && err) begin
        state <= ST_ERR1;
        cnt   <= 4'd0;
      end else if (accept) begin
        state <= ST_DATA;
        cnt   <= 4'(WAIT_STATES);
      end else begin
        state <= ST_IDLE;
      end
    end else begin
      case (state)
        ST_DATA: cnt <= cnt - 4'd1;
`ifdef AHB_SRAM_ERR_RESP_EN
        ST_ERR1: state <= ST_ERR2;
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && HREADYOUT && accept) begin
      addr_q  <= HADDR;
      write_q <= HWRITE;
      size_q  <= HSIZE;
    end
  end

  // Reset gates the commit so an aborted write never reaches the array.
  assign commit = (state == ST_DATA) & (cnt == 4'd0) & write_q & ~reset;

  ahb_sub_bytemem #(
    .W     (AHBW),
    .DEPTH (DEPTH),
    .AW    (IDXB)
  ) u_mem (
    .clk   (clk),
    .en    (commit),
    .addr  (addr_q[OFFB +: IDXB]),
    .wdata (HWDATA),
    .strb  (HWSTRB),
    .rdata (mem_rdata)
  );

  assign HRDATA = (state == ST_DATA) ? mem_rdata : '0;

  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, size_q, HTRANS[0],
                           addr_q[PA_BITS-1:OFFB+IDXB], addr_q[OFFB-1:0]};

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// Directed bench: two instances (0 and 2 wait states) behind a shared bus with an HREADY mux.
module tb_ahb_sram_subordinate;

  localparam logic [33:0] BASE = 34'h0_8000_0000;
  localparam logic [63:0] D0   = 64'h1122_3344_5566_7788;
  localparam logic [63:0] D1   = 64'hA5A5_0000_1234_5678;
  localparam logic [63:0] DS   = 64'h1122_3344_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hsel = 1'b0;
  logic        hwrite = 1'b0;
  logic        use_ws2 = 1'b0;
  logic [1:0]  htrans = 2'b00;
  logic [33:0] haddr = '0;
  logic [2:0]  hsize = 3'd3;
  logic [63:0] hwdata = '0;
  logic [7:0]  hwstrb = 8'hFF;

  logic [63:0] rdata0, rdata2, rdata;
  logic        rdy0, rdy2, rdy, resp0, resp2, resp, hready, hsel0, hsel2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign hsel0  = hsel & ~use_ws2;
  assign hsel2  = hsel & use_ws2;
  assign hready = use_ws2 ? rdy2 : rdy0;
  assign rdy    = hready;
  assign rdata  = use_ws2 ? rdata2 : rdata0;
  assign resp   = use_ws2 ? resp2 : resp0;

  ahb_sram_subordinate #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011),
    .HMASTLOCK(1'b0), .HWDATA(hwdata), .HWSTRB(hwstrb), .HREADY(hready),
    .HRDATA(rdata0), .HREADYOUT(rdy0), .HRESP(resp0)
  );

  ahb_sram_subordinate #(.WAIT_STATES(2)) u_dut2 (
    .clk(clk), .reset(reset), .HSEL(hsel2), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011),
    .HMASTLOCK(1'b0), .HWDATA(hwdata), .HWSTRB(hwstrb), .HREADY(hready),
    .HRDATA(rdata2), .HREADYOUT(rdy2), .HRESP(resp2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic addr_ph(input logic [1:0] tr, input logic wr, input logic [33:0] a, input logic [2:0] sz);
    hsel = 1'b1; htrans = tr; hwrite = wr; haddr = a; hsize = sz;
  endtask

  task automatic idle();
    hsel = 1'b0; htrans = 2'b00;
  endtask

  // Caller is already at a negedge; counts low-ready cycles until ready, bounded.
  task automatic wait_rdy(input string tag, output int lows);
    lows = 0;
    for (int i = 0; i < 20 && !rdy; i++) begin
      lows++;
      nxt();
      mid();
    end
    check(tag, {63'd0, rdy}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lows;

    repeat (3) nxt();
    mid();
    check("rst_rdy",   {63'd0, rdy},  64'd1);
    check("rst_resp",  {63'd0, resp}, 64'd0);
    check("rst_rdata", rdata,         64'd0);
    nxt();
    reset = 1'b0;

    // Back-to-back writes then pipelined reads, no wait states.
    addr_ph(2'b10, 1'b1, BASE, 3'd3);
    mid(); check("t2_rdy0", {63'd0, rdy}, 64'd1); nxt();
    addr_ph(2'b10, 1'b1, BASE + 34'h8, 3'd3); hwdata = D0;
    mid(); check("t2_rdy1", {63'd0, rdy}, 64'd1); nxt();
    addr_ph(2'b10, 1'b0, BASE, 3'd3); hwdata = D1;
    mid(); check("t2_rdy2", {63'd0, rdy}, 64'd1); nxt();
    addr_ph(2'b10, 1'b0, BASE + 34'h8, 3'd3); hwdata = '0;
    mid(); check("t2_rd0", rdata, D0); check("t2_rdy3", {63'd0, rdy}, 64'd1); nxt();
    idle();
    mid(); check("t2_rd1", rdata, D1); check("t2_resp", {63'd0, resp}, 64'd0); nxt();
    mid(); check("t2_idle_rdata", rdata, 64'd0); nxt();

    // Low-half byte strobes over D0.
    addr_ph(2'b10, 1'b1, BASE, 3'd3); nxt();
    addr_ph(2'b10, 1'b0, BASE, 3'd3); hwdata = '1; hwstrb = 8'h0F; nxt();
    idle(); hwstrb = 8'hFF;
    mid(); check("t3_strb", rdata, DS); nxt();

    // Reset for 3 cycles during a write data phase to BASE+8.
    addr_ph(2'b10, 1'b1, BASE + 34'h8, 3'd3); nxt();
    idle(); hwdata = 64'hDEAD_BEEF_CAFE_F00D; reset = 1'b1; nxt();
    mid();
    check("t1_rdy",   {63'd0, rdy},  64'd1);
    check("t1_resp",  {63'd0, resp}, 64'd0);
    check("t1_rdata", rdata,         64'd0);
    nxt(); nxt(); reset = 1'b0;
    addr_ph(2'b10, 1'b0, BASE + 34'h8, 3'd3); nxt();
    idle();
    mid(); check("t1_kept", rdata, D1); nxt();

    // Two wait states on the second instance.
    use_ws2 = 1'b1;
    addr_ph(2'b10, 1'b1, BASE, 3'd3); nxt();
    idle(); hwdata = D0;
    mid(); wait_rdy("t4_wr_rdy", lows);
    check("t4_wr_lows", lows, 64'd2); nxt();
    addr_ph(2'b01, 1'b1, BASE, 3'd3); hwdata = '1; nxt();
    addr_ph(2'b00, 1'b1, BASE, 3'd3);
    mid(); check("t4_busy_rdy", {63'd0, rdy}, 64'd1); check("t4_busy_resp", {63'd0, resp}, 64'd0); nxt();
    idle();
    mid(); check("t4_idle_rdy", {63'd0, rdy}, 64'd1); nxt();
    addr_ph(2'b10, 1'b0, BASE, 3'd3); nxt();
    idle();
    mid(); check("t4_unsel_hold", {63'd0, rdy0}, 64'd1);
    wait_rdy("t4_rd_rdy", lows);
    check("t4_rd_lows", lows, 64'd2);
    check("t4_rd_data", rdata, D0);
    check("t4_rd_resp", {63'd0, resp}, 64'd0);
    nxt();
    use_ws2 = 1'b0;

`ifdef AHB_SRAM_ERR_RESP_EN
    addr_ph(2'b10, 1'b1, BASE + 34'h2000, 3'd3); nxt();
    idle(); hwdata = 64'h5555_5555_5555_5555;
    mid(); check("t5_err1_rdy", {63'd0, rdy}, 64'd0); check("t5_err1_resp", {63'd0, resp}, 64'd1); nxt();
    mid(); check("t5_err2_rdy", {63'd0, rdy}, 64'd1); check("t5_err2_resp", {63'd0, resp}, 64'd1); nxt();
    mid(); check("t5_after_resp", {63'd0, resp}, 64'd0); nxt();
    addr_ph(2'b10, 1'b0, BASE, 3'd3); nxt();
    idle();
    mid(); check("t5_mem", rdata, DS); nxt();
    addr_ph(2'b10, 1'b0, BASE + 34'h2, 3'd2); nxt();
    idle();
    mid(); check("t5_mis_rdy", {63'd0, rdy}, 64'd0); check("t5_mis_resp", {63'd0, resp}, 64'd1); nxt();
    mid(); check("t5_mis2_rdy", {63'd0, rdy}, 64'd1); check("t5_mis2_resp", {63'd0, resp}, 64'd1); nxt();
`else
    addr_ph(2'b10, 1'b1, BASE + 34'h2000, 3'd3); nxt();
    idle(); hwdata = 64'h0123_4567_89AB_CDEF;
    mid(); check("t6_wr_resp", {63'd0, resp}, 64'd0); check("t6_wr_rdy", {63'd0, rdy}, 64'd1); nxt();
    addr_ph(2'b10, 1'b0, BASE, 3'd3); nxt();
    idle();
    mid(); check("t6_alias", rdata, 64'h0123_4567_89AB_CDEF); check("t6_rd_resp", {63'd0, resp}, 64'd0); nxt();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
